// File: rtl/VX_fpu_pkg.sv
// Shared FPU widths and helpers for the FPU request scheduler.
// Request/response payload widths scale with the SIMD lane count.
package VX_fpu_pkg;

  localparam int XLEN          = 32;
  localparam int INST_FPU_BITS = 4;
  localparam int INST_FMT_BITS = 2;
  localparam int INST_FRM_BITS = 3;
  localparam int FP_FLAGS_BITS = 5;

  localparam int INST_BITS =
    INST_FPU_BITS + INST_FMT_BITS + INST_FRM_BITS;

  function automatic int fpu_req_w(input int lanes);
    return INST_BITS + 3 * lanes * XLEN;
  endfunction

  function automatic int fpu_rsp_w(input int lanes);
    return lanes * (XLEN + FP_FLAGS_BITS) + 1;
  endfunction

  localparam int FPU_REQ_W = fpu_req_w(4);
  localparam int FPU_RSP_W = fpu_rsp_w(4);

endpackage

// File: rtl/vx_fpu_sched_if.sv
// Requester-side and FPU-side buses of the FPU scheduler.
// master = scheduler view, slave = surrounding core/FPU view.
interface vx_fpu_sched_if #(
  parameter int NUM_REQS  = 4,
  parameter int NUM_LANES = 4,
  parameter int TAG_WIDTH = 8
);
  import VX_fpu_pkg::*;

  localparam int SEL = $clog2(NUM_REQS);
  localparam int DW  = fpu_req_w(NUM_LANES);
  localparam int RW  = fpu_rsp_w(NUM_LANES);

  logic [NUM_REQS-1:0]           req_valid_in;
  logic [NUM_REQS*DW-1:0]        req_data_in;
  logic [NUM_REQS*TAG_WIDTH-1:0] req_tag_in;
  logic [NUM_REQS-1:0]           req_ready_in;

  logic                     fpu_req_valid;
  logic [DW-1:0]            fpu_req_data;
  logic [TAG_WIDTH+SEL-1:0] fpu_req_tag;
  logic                     fpu_req_ready;

  logic                     fpu_rsp_valid;
  logic [TAG_WIDTH+SEL-1:0] fpu_rsp_tag;
  logic [RW-1:0]            fpu_rsp_data;
  logic                     fpu_rsp_ready;

  logic [NUM_REQS-1:0]  rsp_valid_out;
  logic [TAG_WIDTH-1:0] rsp_tag_out;
  logic [RW-1:0]        rsp_data_out;
  logic [NUM_REQS-1:0]  rsp_ready_out;

  modport master (
    input  req_valid_in, req_data_in, req_tag_in,
    output req_ready_in,
    output fpu_req_valid, fpu_req_data, fpu_req_tag,
    input  fpu_req_ready,
    input  fpu_rsp_valid, fpu_rsp_tag, fpu_rsp_data,
    output fpu_rsp_ready,
    output rsp_valid_out, rsp_tag_out, rsp_data_out,
    input  rsp_ready_out
  );

  modport slave (
    output req_valid_in, req_data_in, req_tag_in,
    input  req_ready_in,
    input  fpu_req_valid, fpu_req_data, fpu_req_tag,
    output fpu_req_ready,
    output fpu_rsp_valid, fpu_rsp_tag, fpu_rsp_data,
    input  fpu_rsp_ready,
    input  rsp_valid_out, rsp_tag_out, rsp_data_out,
    output rsp_ready_out
  );

endinterface

// File: rtl/VX_rr_arbiter.sv
// Round-robin arbiter: top priority moves to the index just
// after the last accepted grant, wrapping to 0.
module VX_rr_arbiter #(
  parameter int N   = 4,
  parameter int SEL = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_i,
  input  logic           adv_i,
  output logic [N-1:0]   gnt_o,
  output logic [SEL-1:0] idx_o,
  output logic           valid_o
);

  logic [SEL-1:0] prio_q, prio_d;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = 0; k < N; k++) begin
      if (!valid_o && req_i[(int'(prio_q) + k) % N]) begin
        valid_o = 1'b1;
        idx_o   = SEL'((int'(prio_q) + k) % N);
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    for (int i = 0; i < N; i++) begin
      gnt_o[i] = valid_o && (idx_o == SEL'(i));
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (adv_i && valid_o) begin
      if (int'(idx_o) == N - 1) prio_d = '0;
      else                      prio_d = idx_o + SEL'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= '0;
    else        prio_q <= prio_d;
  end

endmodule

// File: rtl/vx_fpu_sched.sv
// Shares one FPU among NUM_REQS requesters with per-requester
// credit limits, a one-deep output register and tag-routed responses.
module vx_fpu_sched
  import VX_fpu_pkg::*;
#(
  parameter int NUM_REQS    = 4,
  parameter int NUM_LANES   = 4,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic drain,
  output logic idle,
  vx_fpu_sched_if.master bus
);

  localparam int SEL = $clog2(NUM_REQS);
  localparam int DW  = fpu_req_w(NUM_LANES);
  localparam int CW  = $clog2(MAX_PENDING + 1);
  localparam logic [CW-1:0] MAXP = CW'(MAX_PENDING);

  logic [NUM_REQS-1:0] elig_c;
  logic [NUM_REQS-1:0] gnt_c;
  logic [SEL-1:0]      gidx_c;
  logic                gvld_c;
  logic                load_c;
  logic                accept_c;

  logic [CW-1:0] pend_q [NUM_REQS];
  logic [CW-1:0] pend_d [NUM_REQS];
  logic [NUM_REQS-1:0] inc_c;
  logic [NUM_REQS-1:0] dec_c;

  logic                     vld_q, vld_d;
  logic [DW-1:0]            dat_q, dat_d;
  logic [TAG_WIDTH+SEL-1:0] tag_q, tag_d;

  logic [SEL-1:0] rsel_c;
  logic           rsel_ok_c;
  logic           rrdy_c;
  logic           rfire_c;

  always_comb begin
    elig_c = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      elig_c[i] = bus.req_valid_in[i]
               && (pend_q[i] < MAXP) && !drain;
    end
  end

  VX_rr_arbiter #(
    .N   (NUM_REQS),
    .SEL (SEL)
  ) u_arb (
    .clk     (clk),
    .rst_n   (reset_n),
    .req_i   (elig_c),
    .adv_i   (accept_c),
    .gnt_o   (gnt_c),
    .idx_o   (gidx_c),
    .valid_o (gvld_c)
  );

  // A grant may only land when the slot is free or draining now.
  assign load_c   = reset_n && (!vld_q || bus.fpu_req_ready);
  assign accept_c = gvld_c && load_c;

  assign bus.req_ready_in = gnt_c & {NUM_REQS{load_c}};

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    tag_d = tag_q;
    if (load_c) begin
      vld_d = gvld_c;
      if (gvld_c) begin
        dat_d = bus.req_data_in[gidx_c*DW +: DW];
        tag_d = {bus.req_tag_in[gidx_c*TAG_WIDTH +: TAG_WIDTH],
                 gidx_c};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= 1'b0;
      dat_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      tag_q <= tag_d;
    end
  end

  assign bus.fpu_req_valid = vld_q;
  assign bus.fpu_req_data  = dat_q;
  assign bus.fpu_req_tag   = tag_q;

  assign rsel_c    = bus.fpu_rsp_tag[SEL-1:0];
  assign rsel_ok_c = int'(rsel_c) < NUM_REQS;
  assign rrdy_c    = reset_n && rsel_ok_c
                  && bus.rsp_ready_out[rsel_c];
  assign rfire_c   = bus.fpu_rsp_valid && rrdy_c;

  always_comb begin
    bus.rsp_valid_out = '0;
    if (reset_n && rsel_ok_c && bus.fpu_rsp_valid) begin
      bus.rsp_valid_out[rsel_c] = 1'b1;
    end
  end

  assign bus.fpu_rsp_ready = rrdy_c;
  assign bus.rsp_tag_out   = bus.fpu_rsp_tag[SEL +: TAG_WIDTH];
  assign bus.rsp_data_out  = bus.fpu_rsp_data;

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      inc_c[i]  = accept_c && (gidx_c == SEL'(i));
      dec_c[i]  = rfire_c && (rsel_c == SEL'(i));
      pend_d[i] = pend_q[i];
      if (inc_c[i] && !dec_c[i]) pend_d[i] = pend_q[i] + CW'(1);
      if (dec_c[i] && !inc_c[i]) pend_d[i] = pend_q[i] - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQS; i++) pend_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQS; i++) pend_q[i] <= pend_d[i];
    end
  end

  always_comb begin
    idle = !vld_q;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (pend_q[i] != '0) idle = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (reset_n) begin
      assert (!(bus.fpu_rsp_valid && !rsel_ok_c));
      for (int i = 0; i < NUM_REQS; i++) begin
        assert (!(dec_c[i] && pend_q[i] == '0));
        assert (!(inc_c[i] && !dec_c[i] && pend_q[i] == MAXP));
      end
    end
  end

endmodule

// File: tb/tb_vx_fpu_sched.sv
// Directed bench for vx_fpu_sched: arbitration, credits, stall,
// response routing, drain/idle and mid-run reset.
module tb_vx_fpu_sched;
  import VX_fpu_pkg::*;

  localparam int NR = 4;
  localparam int DW = fpu_req_w(4);

  logic clk;
  logic reset_n;
  logic drain;
  logic idle;

  int checks   = 0;
  int failures = 0;

  vx_fpu_sched_if #(
    .NUM_REQS(NR), .NUM_LANES(4), .TAG_WIDTH(8)
  ) bus ();

  vx_fpu_sched #(
    .NUM_REQS(NR), .NUM_LANES(4),
    .TAG_WIDTH(8), .MAX_PENDING(2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .drain   (drain),
    .idle    (idle),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [63:0] v);
    bus.req_data_in[i*DW +: 64] = v;
  endtask

  task automatic rsp_once(input logic [1:0] idx);
    bus.fpu_rsp_valid = 1'b1;
    bus.fpu_rsp_tag   = {8'h5A, idx};
    tick();
    bus.fpu_rsp_valid = 1'b0;
  endtask

  initial begin
    reset_n           = 1'b0;
    drain             = 1'b0;
    bus.req_valid_in  = 4'hF;
    bus.req_data_in   = '0;
    bus.req_tag_in    = '0;
    bus.fpu_req_ready = 1'b1;
    bus.fpu_rsp_valid = 1'b0;
    bus.fpu_rsp_tag   = '0;
    bus.fpu_rsp_data  = '0;
    bus.rsp_ready_out = 4'hF;
    for (int i = 0; i < NR; i++) begin
      set_data(i, 64'hDA7A_0000_0000_0000 + 64'(i));
      bus.req_tag_in[i*8 +: 8] = 8'h10 + 8'(i);
    end
    repeat (2) @(posedge clk);
    #1;

    check("rst_req_ready", 64'(bus.req_ready_in), 64'h0);
    check("rst_rsp_valid", 64'(bus.rsp_valid_out), 64'h0);
    check("rst_fpu_rsp_ready", 64'(bus.fpu_rsp_ready), 64'h0);
    check("rst_idle", 64'(idle), 64'h1);
    check("rst_fpu_req_valid", 64'(bus.fpu_req_valid), 64'h0);

    reset_n = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("s1_ready", 64'(bus.req_ready_in), 64'(1) << (k % 4));
      tick();
      check("s1_valid", 64'(bus.fpu_req_valid), 64'h1);
      check("s1_idx", 64'(bus.fpu_req_tag[1:0]), 64'(k % 4));
      check("s1_tag", 64'(bus.fpu_req_tag[9:2]), 64'(8'h10 + k % 4));
      check("s1_data", bus.fpu_req_data[63:0],
            64'hDA7A_0000_0000_0000 + 64'(k % 4));
    end
    bus.req_valid_in = 4'h0;
    tick();
    check("s1_empty", 64'(bus.fpu_req_valid), 64'h0);
    check("s1_busy", 64'(idle), 64'h0);

    bus.fpu_rsp_valid = 1'b1;
    bus.fpu_rsp_tag   = {8'hA5, 2'd2};
    bus.fpu_rsp_data  = '0;
    bus.fpu_rsp_data[63:0] = 64'hFEED_0000_1234_5678;
    bus.rsp_ready_out = 4'b1011;
    #1;
    check("s4_rsp_valid", 64'(bus.rsp_valid_out), 64'h4);
    check("s4_rsp_tag", 64'(bus.rsp_tag_out), 64'hA5);
    check("s4_rsp_data", bus.rsp_data_out[63:0],
          64'hFEED_0000_1234_5678);
    check("s4_not_ready", 64'(bus.fpu_rsp_ready), 64'h0);
    tick();
    check("s4_hold_valid", 64'(bus.rsp_valid_out), 64'h4);
    bus.rsp_ready_out = 4'hF;
    #1;
    check("s4_ready", 64'(bus.fpu_rsp_ready), 64'h1);
    tick();
    bus.fpu_rsp_valid = 1'b0;
    rsp_once(2'd0);
    rsp_once(2'd0);
    rsp_once(2'd1);
    #1;
    check("s4_busy_r3", 64'(idle), 64'h0);

    bus.req_valid_in  = 4'b1000;
    bus.fpu_rsp_valid = 1'b1;
    bus.fpu_rsp_tag   = {8'h33, 2'd3};
    #1;
    check("s5_ready", 64'(bus.req_ready_in), 64'h8);
    check("s5_rsp_ready", 64'(bus.fpu_rsp_ready), 64'h1);
    tick();
    bus.req_valid_in  = 4'h0;
    bus.fpu_rsp_valid = 1'b0;
    check("s5_idx", 64'(bus.fpu_req_tag[1:0]), 64'h3);
    tick();
    check("s5_busy", 64'(idle), 64'h0);
    rsp_once(2'd3);
    #1;
    check("s5_idle", 64'(idle), 64'h1);

    bus.req_valid_in = 4'b0010;
    #1;
    check("s2_ready0", 64'(bus.req_ready_in), 64'h2);
    tick();
    check("s2_ready1", 64'(bus.req_ready_in), 64'h2);
    tick();
    check("s2_full", 64'(bus.req_ready_in), 64'h0);
    tick();
    check("s2_still_full", 64'(bus.req_ready_in), 64'h0);
    check("s2_empty", 64'(bus.fpu_req_valid), 64'h0);
    bus.fpu_rsp_valid = 1'b1;
    bus.fpu_rsp_tag   = {8'h44, 2'd1};
    #1;
    check("s2_same_cycle", 64'(bus.req_ready_in), 64'h0);
    tick();
    bus.fpu_rsp_valid = 1'b0;
    #1;
    check("s2_resume", 64'(bus.req_ready_in), 64'h2);
    tick();
    bus.req_valid_in = 4'h0;
    tick();

    bus.fpu_req_ready = 1'b0;
    bus.req_valid_in  = 4'b0001;
    #1;
    check("s3_ready", 64'(bus.req_ready_in), 64'h1);
    tick();
    set_data(0, 64'h0000_0000_0000_BAD0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("s3_valid", 64'(bus.fpu_req_valid), 64'h1);
      check("s3_tag", 64'(bus.fpu_req_tag), 64'h040);
      check("s3_data", bus.fpu_req_data[63:0],
            64'hDA7A_0000_0000_0000);
      check("s3_no_grant", 64'(bus.req_ready_in), 64'h0);
      tick();
    end
    bus.fpu_req_ready = 1'b1;
    bus.req_valid_in  = 4'h0;
    tick();
    check("s3_fired", 64'(bus.fpu_req_valid), 64'h0);
    bus.req_valid_in = 4'b0001;
    #1;
    check("s3_one_credit", 64'(bus.req_ready_in), 64'h1);
    tick();
    check("s3_once", 64'(bus.req_ready_in), 64'h0);
    bus.req_valid_in = 4'h0;
    tick();
    rsp_once(2'd0);
    rsp_once(2'd1);

    drain            = 1'b1;
    bus.req_valid_in = 4'hF;
    #1;
    check("s6_no_grant", 64'(bus.req_ready_in), 64'h0);
    tick();
    check("s6_no_grant2", 64'(bus.req_ready_in), 64'h0);
    check("s6_no_req", 64'(bus.fpu_req_valid), 64'h0);
    check("s6_busy", 64'(idle), 64'h0);
    rsp_once(2'd0);
    #1;
    check("s6_busy1", 64'(idle), 64'h0);
    rsp_once(2'd1);
    #1;
    check("s6_idle", 64'(idle), 64'h1);
    drain = 1'b0;
    #1;
    check("s6_rr_next", 64'(bus.req_ready_in), 64'h2);
    bus.fpu_req_ready = 1'b0;
    tick();
    check("s6_staged", 64'(bus.fpu_req_valid), 64'h1);
    check("s6_not_idle", 64'(idle), 64'h0);
    reset_n = 1'b0;
    #1;
    check("rst_mid_valid", 64'(bus.fpu_req_valid), 64'h0);
    check("rst_mid_idle", 64'(idle), 64'h1);
    check("rst_mid_ready", 64'(bus.req_ready_in), 64'h0);
    tick();
    reset_n = 1'b1;
    #1;
    check("rst_prio0", 64'(bus.req_ready_in), 64'h1);
    bus.req_valid_in = 4'h0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vx_fpu_sched.md
VX_FPU_SCHED -- requirements
Module: VX_fpu_sched

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4, number of requesters sharing one FPU (2..8).
REQ-002 SHALL have parameter NUM_LANES, default 4, SIMD lanes per request.
REQ-003 SHALL have parameter TAG_WIDTH, default 8, requester tag width.
REQ-004 SHALL have parameter MAX_PENDING, default 4, in-flight limit per requester (1..15).
REQ-005 SHALL have ports, with SEL = clog2(NUM_REQS) and DW = INST_FPU_BITS+INST_FMT_BITS+INST_FRM_BITS+3*NUM_LANES*XLEN:
- clk  in  1  clock; one clock domain.
- reset_n  in  1  reset, asynchronous, active-low.
- req_valid_in  in  NUM_REQS  per-requester request valid.
- req_data_in  in  NUM_REQS*DW  per-requester {op_type, fmt, frm, dataa, datab, datac}.
- req_tag_in  in  NUM_REQS*TAG_WIDTH  per-requester tag.
- req_ready_in  out  NUM_REQS  per-requester accept.
- fpu_req_valid  out  1  request to FPU.
- fpu_req_data  out  DW  forwarded payload.
- fpu_req_tag  out  TAG_WIDTH+SEL  {requester tag, requester index}, index in LSBs.
- fpu_req_ready  in  1  FPU accept.
- fpu_rsp_valid  in  1  FPU response valid.
- fpu_rsp_tag  in  TAG_WIDTH+SEL  returned tag.
- fpu_rsp_data  in  NUM_LANES*(XLEN+FP_FLAGS_BITS)+1  {result, fflags, has_fflags}.
- fpu_rsp_ready  out  1  response accept.
- rsp_valid_out  out  NUM_REQS  per-requester response valid.
- rsp_tag_out  out  TAG_WIDTH  stripped tag, shared by all requesters.
- rsp_data_out  out  NUM_LANES*(XLEN+FP_FLAGS_BITS)+1  shared response payload.
- rsp_ready_out  in  NUM_REQS  per-requester response accept.
- drain  in  1  stop new grants while high.
- idle  out  1  no staged request and all credits full.

Function
REQ-006 SHALL keep a per-requester pending counter of width clog2(MAX_PENDING+1).
REQ-007 SHALL treat requester i as eligible when req_valid_in[i] is high, pending[i] < MAX_PENDING, and drain is low.
REQ-008 SHALL pick one eligible requester per cycle by round-robin; priority starts just after the last granted index and wraps from NUM_REQS-1 to 0.
REQ-009 SHALL drive req_ready_in[i] high only for the granted i, and only when the output register is empty or is firing (fpu_req_valid & fpu_req_ready) that cycle.
REQ-010 SHALL register the granted payload and {tag, index} into one output register, giving a latency of one cycle from grant to fpu_req_valid.
REQ-011 SHALL hold fpu_req_valid, data and tag stable while fpu_req_ready is low.
REQ-012 SHALL sustain one request per cycle when fpu_req_ready stays high.
REQ-013 SHALL increment pending[i] on a grant to i and decrement it on a response fire to i; both in one cycle SHALL leave it unchanged.
REQ-014 SHALL route a response to index s = fpu_rsp_tag[SEL-1:0]:
- rsp_valid_out[s] = fpu_rsp_valid; every other rsp_valid_out bit low.
- rsp_tag_out = fpu_rsp_tag[SEL +: TAG_WIDTH].
- fpu_rsp_ready = rsp_ready_out[s].
- The response path is combinational, zero latency.
REQ-015 SHALL keep drain and idle as follows:
- drain affects only new grants; the staged request and responses complete normally.
- idle = output register empty AND all pending counters zero.
REQ-016 SHALL carry a simulation assertion for each error case:
- s >= NUM_REQS with fpu_rsp_valid high.
- A response to a requester whose pending counter is zero.
- A counter overflow.

Reset
REQ-017 SHALL, while reset_n is low, clear all of the following:
- Pending counters to 0.
- fpu_req_valid to 0.
- Round-robin pointer to index 0, so requester 0 has top priority.
REQ-018 SHALL give the outputs these reset values: req_ready_in 0, rsp_valid_out 0, fpu_rsp_ready 0, idle 1.
REQ-019 SHALL discard any staged or in-flight request when reset is asserted mid-operation; the FPU is reset together with this block.

Structure
REQ-020 SHALL keep these shared definitions in the FPU package VX_fpu_pkg: INST_FPU_BITS, INST_FMT_BITS, INST_FRM_BITS, FP_FLAGS_BITS, XLEN, and the payload/response width localparams.
REQ-021 SHALL use one sub-module, VX_rr_arbiter, for the round-robin grant; counters, output register and response routing stay in this block.

Verification
REQ-022 SHALL cover these directed scenarios:
- NUM_REQS=4; all valid; fpu_req_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; fpu_req_tag LSBs 0,1,2,3,0.
- MAX_PENDING=2; only requester 1 valid; no responses -> two grants, then req_ready_in[1]=0 and pending[1]=2; one response tagged index 1 -> grant resumes the next cycle.
- fpu_req_ready=0 for 3 cycles with a request staged -> fpu_req_valid/data/tag unchanged; no new grant; pending incremented once.
- Response with tag {8'hA5, 2'd2} and rsp_ready_out[2]=0 -> rsp_valid_out=4'b0100, rsp_tag_out=8'hA5, fpu_rsp_ready=0; raising rsp_ready_out[2] -> fire; pending[2] decrements.
- Grant to 3 and response to 3 in the same cycle -> pending[3] unchanged.
- drain=1 with 2 outstanding -> no grants; idle=1 after the 2nd response; reset_n low mid-operation -> fpu_req_valid=0, idle=1 immediately.
